// File: rtl/debug_tx_sequencer.sv
// Streams a debug frame (header, pc, cycle count, register file) over a byte-wide UART handshake.
// Optional trailing XOR checksum byte when DEBUG_TX_CHECKSUM_EN is defined.
module debug_tx_sequencer #(
   parameter int unsigned          LEN      = 32,
   parameter int unsigned          N_REGS   = 32,
   parameter int unsigned          LEN_DATA = 8,
   parameter logic [LEN_DATA-1:0]  HEADER   = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN-1:0]        pc,
   input  logic [LEN-1:0]        ciclos,
   input  logic [LEN*N_REGS-1:0] regs,
   input  logic                  tx_done,
   output logic                  tx_start,
   output logic [LEN_DATA-1:0]   uart_data_out,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned WordW = $clog2(N_REGS + 2);
   localparam logic [WordW-1:0] LastWord = WordW'(N_REGS + 1);

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StWait,
      StNext,
`ifdef DEBUG_TX_CHECKSUM_EN
      StCheck,
`endif
      StFinish
   } state_e;

   state_e                state_q, state_d;
   logic [LEN-1:0]        pc_q, pc_d;
   logic [LEN-1:0]        ciclos_q, ciclos_d;
   logic [LEN*N_REGS-1:0] regs_q, regs_d;
   logic [WordW-1:0]      word_q, word_d;
   logic [1:0]            byte_q, byte_d;
   logic                  hdr_q, hdr_d;
`ifdef DEBUG_TX_CHECKSUM_EN
   logic [LEN_DATA-1:0]   csum_q, csum_d;
   logic                  chk_q, chk_d;
`endif

   logic [LEN-1:0]      word_sel;
   logic [LEN_DATA-1:0] cur_byte;
   logic [LEN_DATA-1:0] out_byte;
   logic                last_byte;
   int unsigned         ridx;

   // Word 0 is pc, word 1 is ciclos, words 2.. are the register file.
   always_comb begin
      ridx = 32'(word_q) - 32'd2;
      if (word_q < WordW'(2) || ridx >= N_REGS) ridx = 0;
      if (word_q == '0)              word_sel = pc_q;
      else if (word_q == WordW'(1))  word_sel = ciclos_q;
      else                           word_sel = regs_q[ridx*LEN +: LEN];
      cur_byte  = hdr_q ? HEADER : word_sel[32'(byte_q)*LEN_DATA +: LEN_DATA];
      last_byte = !hdr_q && (byte_q == 2'd3) && (word_q == LastWord);
`ifdef DEBUG_TX_CHECKSUM_EN
      out_byte  = chk_q ? csum_q : cur_byte;
`else
      out_byte  = cur_byte;
`endif
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ciclos_d      = ciclos_q;
      regs_d        = regs_q;
      word_d        = word_q;
      byte_d        = byte_q;
      hdr_d         = hdr_q;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_d        = csum_q;
      chk_d         = chk_q;
`endif
      tx_start      = 1'b0;
      uart_data_out = '0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               pc_d     = pc;
               ciclos_d = ciclos;
               regs_d   = regs;
               word_d   = '0;
               byte_d   = '0;
               hdr_d    = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
               csum_d   = '0;
               chk_d    = 1'b0;
`endif
               state_d  = StSend;
            end
         end
         StSend: begin
            busy          = 1'b1;
            tx_start      = 1'b1;
            uart_data_out = cur_byte;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_d        = csum_q ^ cur_byte;
`endif
            state_d       = StWait;
         end
         StWait: begin
            busy          = 1'b1;
            uart_data_out = out_byte;
            if (tx_done) state_d = StNext;
         end
         StNext: begin
            busy          = 1'b1;
            uart_data_out = out_byte;
`ifdef DEBUG_TX_CHECKSUM_EN
            if (chk_q)          state_d = StFinish;
            else if (last_byte) state_d = StCheck;
`else
            if (last_byte)      state_d = StFinish;
`endif
            else begin
               state_d = StSend;
               if (hdr_q) begin
                  hdr_d = 1'b0;
               end else begin
                  byte_d = byte_q + 2'd1;
                  if (byte_q == 2'd3) word_d = word_q + WordW'(1);
               end
            end
         end
`ifdef DEBUG_TX_CHECKSUM_EN
         StCheck: begin
            busy          = 1'b1;
            tx_start      = 1'b1;
            uart_data_out = csum_q;
            chk_d         = 1'b1;
            state_d       = StWait;
         end
`endif
         StFinish: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         ciclos_q <= '0;
         regs_q   <= '0;
         word_q   <= '0;
         byte_q   <= '0;
         hdr_q    <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
         csum_q   <= '0;
         chk_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ciclos_q <= ciclos_d;
         regs_q   <= regs_d;
         word_q   <= word_d;
         byte_q   <= byte_d;
         hdr_q    <= hdr_d;
`ifdef DEBUG_TX_CHECKSUM_EN
         csum_q   <= csum_d;
         chk_q    <= chk_d;
`endif
      end
   end

endmodule
